dbchecker_rx_wbuf: RTL and testbench

DBCHECKER_RX_WBUF -- requirements
Module: dbchecker_rx_wbuf

---
 rtl/dbchecker_pkg.sv | 36 +++
 rtl/dbchecker_sync_fifo.sv | 58 +++++
 rtl/dbchecker_rx_wbuf.sv | 227 ++++++++++++++++++++++
 tb/tb_dbchecker_rx_wbuf.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbchecker_pkg.sv
// Shared AXI rx field widths and payload bundles
// for the DBChecker rx write-buffer slice.
package dbchecker_pkg;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 128;
  localparam int STRB_W = 16;
  localparam int LEN_W  = 8;
  localparam int CNT_W  = 8;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [3:0]        cache;
    logic              lock;
    logic [2:0]        prot;
    logic [3:0]        qos;
    logic [3:0]        region;
  } aw_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } w_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_t;

endpackage

// File: rtl/dbchecker_sync_fifo.sv
// Generic single-clock FIFO with wrap-bit pointers.
// Output data reads as zero while the FIFO is empty.
module dbchecker_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] rdata_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_en;
  logic             pop_en;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0])
                && (wr_q[AW] != rd_q[AW]);

  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  // Advance pointers on accepted push/pop
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_en) wr_d = wr_q + 1'b1;
    if (pop_en)  rd_d = rd_q + 1'b1;
  end

  // Pointer registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage array, written at the tail slot
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/dbchecker_rx_wbuf.sv
// AXI rx write buffer: AW/W FIFOs, B slice, outstanding limit.
// Optional stall counters: DBCHECKER_RX_WBUF_STATS_EN.
module dbchecker_rx_wbuf
  import dbchecker_pkg::*;
#(
  parameter int AW_DEPTH  = 4,
  parameter int W_DEPTH   = 16,
  parameter int MAX_OUTST = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ID_W-1:0]   s_axi_io_rx_awid,
  input  logic [ADDR_W-1:0] s_axi_io_rx_awaddr,
  input  logic [LEN_W-1:0]  s_axi_io_rx_awlen,
  input  logic [2:0]        s_axi_io_rx_awsize,
  input  logic [1:0]        s_axi_io_rx_awburst,
  input  logic [3:0]        s_axi_io_rx_awcache,
  input  logic              s_axi_io_rx_awlock,
  input  logic [2:0]        s_axi_io_rx_awprot,
  input  logic [3:0]        s_axi_io_rx_awqos,
  input  logic [3:0]        s_axi_io_rx_awregion,
  input  logic              s_axi_io_rx_awvalid,
  output logic              s_axi_io_rx_awready,
  input  logic [DATA_W-1:0] s_axi_io_rx_wdata,
  input  logic [STRB_W-1:0] s_axi_io_rx_wstrb,
  input  logic              s_axi_io_rx_wlast,
  input  logic              s_axi_io_rx_wvalid,
  output logic              s_axi_io_rx_wready,
  output logic [ID_W-1:0]   s_axi_io_rx_bid,
  output logic [1:0]        s_axi_io_rx_bresp,
  output logic              s_axi_io_rx_bvalid,
  input  logic              s_axi_io_rx_bready,
  output logic [ID_W-1:0]   m_axi_io_rx_awid,
  output logic [ADDR_W-1:0] m_axi_io_rx_awaddr,
  output logic [LEN_W-1:0]  m_axi_io_rx_awlen,
  output logic [2:0]        m_axi_io_rx_awsize,
  output logic [1:0]        m_axi_io_rx_awburst,
  output logic [3:0]        m_axi_io_rx_awcache,
  output logic              m_axi_io_rx_awlock,
  output logic [2:0]        m_axi_io_rx_awprot,
  output logic [3:0]        m_axi_io_rx_awqos,
  output logic [3:0]        m_axi_io_rx_awregion,
  output logic              m_axi_io_rx_awvalid,
  input  logic              m_axi_io_rx_awready,
  output logic [DATA_W-1:0] m_axi_io_rx_wdata,
  output logic [STRB_W-1:0] m_axi_io_rx_wstrb,
  output logic              m_axi_io_rx_wlast,
  output logic              m_axi_io_rx_wvalid,
  input  logic              m_axi_io_rx_wready,
  input  logic [ID_W-1:0]   m_axi_io_rx_bid,
  input  logic [1:0]        m_axi_io_rx_bresp,
  input  logic              m_axi_io_rx_bvalid,
  output logic              m_axi_io_rx_bready,
  output logic [CNT_W-1:0]  outst_cnt
`ifdef DBCHECKER_RX_WBUF_STATS_EN
  ,
  output logic [31:0]       aw_stall_cnt,
  output logic [31:0]       w_stall_cnt
`endif
);

  aw_t s_aw, m_aw;
  w_t  s_w, m_w;
  b_t  m_b, b_q, b_d;

  logic             rdy_q;
  logic             aw_full, aw_empty;
  logic             w_full, w_empty;
  logic             b_full_q, b_full_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic             aw_push, aw_hs;
  logic             w_push, w_hs;
  logic             b_load, b_hs, b_dec;

  assign s_aw.id     = s_axi_io_rx_awid;
  assign s_aw.addr   = s_axi_io_rx_awaddr;
  assign s_aw.len    = s_axi_io_rx_awlen;
  assign s_aw.size   = s_axi_io_rx_awsize;
  assign s_aw.burst  = s_axi_io_rx_awburst;
  assign s_aw.cache  = s_axi_io_rx_awcache;
  assign s_aw.lock   = s_axi_io_rx_awlock;
  assign s_aw.prot   = s_axi_io_rx_awprot;
  assign s_aw.qos    = s_axi_io_rx_awqos;
  assign s_aw.region = s_axi_io_rx_awregion;

  assign m_axi_io_rx_awid     = m_aw.id;
  assign m_axi_io_rx_awaddr   = m_aw.addr;
  assign m_axi_io_rx_awlen    = m_aw.len;
  assign m_axi_io_rx_awsize   = m_aw.size;
  assign m_axi_io_rx_awburst  = m_aw.burst;
  assign m_axi_io_rx_awcache  = m_aw.cache;
  assign m_axi_io_rx_awlock   = m_aw.lock;
  assign m_axi_io_rx_awprot   = m_aw.prot;
  assign m_axi_io_rx_awqos    = m_aw.qos;
  assign m_axi_io_rx_awregion = m_aw.region;

  assign s_w.data = s_axi_io_rx_wdata;
  assign s_w.strb = s_axi_io_rx_wstrb;
  assign s_w.last = s_axi_io_rx_wlast;

  assign m_axi_io_rx_wdata = m_w.data;
  assign m_axi_io_rx_wstrb = m_w.strb;
  assign m_axi_io_rx_wlast = m_w.last;

  assign m_b.id   = m_axi_io_rx_bid;
  assign m_b.resp = m_axi_io_rx_bresp;

  assign s_axi_io_rx_bid    = b_q.id;
  assign s_axi_io_rx_bresp  = b_q.resp;
  assign s_axi_io_rx_bvalid = b_full_q;

  // Readies are held low until the first edge after reset
  assign s_axi_io_rx_awready = rdy_q && !aw_full;
  assign s_axi_io_rx_wready  = rdy_q && !w_full;
  assign m_axi_io_rx_bready  = rdy_q
                            && (!b_full_q || s_axi_io_rx_bready);

  assign m_axi_io_rx_awvalid = !aw_empty
                            && (outst_q < CNT_W'(MAX_OUTST));
  assign m_axi_io_rx_wvalid  = !w_empty;

  assign aw_push = s_axi_io_rx_awvalid && s_axi_io_rx_awready;
  assign aw_hs   = m_axi_io_rx_awvalid && m_axi_io_rx_awready;
  assign w_push  = s_axi_io_rx_wvalid && s_axi_io_rx_wready;
  assign w_hs    = m_axi_io_rx_wvalid && m_axi_io_rx_wready;
  assign b_load  = m_axi_io_rx_bvalid && m_axi_io_rx_bready;
  assign b_hs    = b_full_q && s_axi_io_rx_bready;
  assign b_dec   = b_hs && (outst_q != '0);

  assign outst_cnt = outst_q;

  dbchecker_sync_fifo #(
    .WIDTH ($bits(aw_t)),
    .DEPTH (AW_DEPTH)
  ) u_aw_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .push_i  (aw_push),
    .wdata_i (s_aw),
    .pop_i   (aw_hs),
    .full_o  (aw_full),
    .empty_o (aw_empty),
    .rdata_o (m_aw)
  );

  dbchecker_sync_fifo #(
    .WIDTH ($bits(w_t)),
    .DEPTH (W_DEPTH)
  ) u_w_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .push_i  (w_push),
    .wdata_i (s_w),
    .pop_i   (w_hs),
    .full_o  (w_full),
    .empty_o (w_empty),
    .rdata_o (m_w)
  );

  // Outstanding count: issue adds, response retires, floor at zero
  always_comb begin
    outst_d = outst_q;
    unique case ({aw_hs, b_dec})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase
  end

  // B slice: load when empty or draining, clear on drain
  always_comb begin
    b_full_d = b_full_q;
    b_d      = b_q;
    if (b_hs) b_full_d = 1'b0;
    if (b_load) begin
      b_full_d = 1'b1;
      b_d      = m_b;
    end
  end

  // Control state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q    <= 1'b0;
      outst_q  <= '0;
      b_full_q <= 1'b0;
      b_q      <= '0;
    end else begin
      rdy_q    <= 1'b1;
      outst_q  <= outst_d;
      b_full_q <= b_full_d;
      b_q      <= b_d;
    end
  end

`ifdef DBCHECKER_RX_WBUF_STATS_EN
  logic [31:0] aw_stall_q, aw_stall_d;
  logic [31:0] w_stall_q, w_stall_d;

  // Saturating per-channel downstream stall counters
  always_comb begin
    aw_stall_d = aw_stall_q;
    w_stall_d  = w_stall_q;
    if (m_axi_io_rx_awvalid && !m_axi_io_rx_awready
        && (aw_stall_q != '1))
      aw_stall_d = aw_stall_q + 1'b1;
    if (m_axi_io_rx_wvalid && !m_axi_io_rx_wready
        && (w_stall_q != '1))
      w_stall_d = w_stall_q + 1'b1;
  end

  // Stall counter registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      aw_stall_q <= '0;
      w_stall_q  <= '0;
    end else begin
      aw_stall_q <= aw_stall_d;
      w_stall_q  <= w_stall_d;
    end
  end

  assign aw_stall_cnt = aw_stall_q;
  assign w_stall_cnt  = w_stall_q;
`endif

endmodule

// File: tb/tb_dbchecker_rx_wbuf.sv
// Self-checking bench for dbchecker_rx_wbuf: queue model,
// directed scenarios, then randomized traffic with resets.
module tb_dbchecker_rx_wbuf;

  localparam int AWD = 4;
  localparam int WD  = 16;
  localparam int MO  = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  logic [3:0]   s_awid;
  logic [63:0]  s_awaddr;
  logic [7:0]   s_awlen;
  logic [2:0]   s_awsize;
  logic [1:0]   s_awburst;
  logic [3:0]   s_awcache;
  logic         s_awlock;
  logic [2:0]   s_awprot;
  logic [3:0]   s_awqos;
  logic [3:0]   s_awregion;
  logic         s_awvalid;
  logic         s_awready;
  logic [127:0] s_wdata;
  logic [15:0]  s_wstrb;
  logic         s_wlast;
  logic         s_wvalid;
  logic         s_wready;
  logic [3:0]   s_bid;
  logic [1:0]   s_bresp;
  logic         s_bvalid;
  logic         s_bready;
  logic [3:0]   m_awid;
  logic [63:0]  m_awaddr;
  logic [7:0]   m_awlen;
  logic [2:0]   m_awsize;
  logic [1:0]   m_awburst;
  logic [3:0]   m_awcache;
  logic         m_awlock;
  logic [2:0]   m_awprot;
  logic [3:0]   m_awqos;
  logic [3:0]   m_awregion;
  logic         m_awvalid;
  logic         m_awready;
  logic [127:0] m_wdata;
  logic [15:0]  m_wstrb;
  logic         m_wlast;
  logic         m_wvalid;
  logic         m_wready;
  logic [3:0]   m_bid;
  logic [1:0]   m_bresp;
  logic         m_bvalid;
  logic         m_bready;
  logic [7:0]   outst_cnt;
`ifdef DBCHECKER_RX_WBUF_STATS_EN
  logic [31:0]  aw_stall_cnt;
  logic [31:0]  w_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [96:0]  awq[$];
  logic [144:0] wq[$];
  bit           bslot = 0;
  logic [5:0]   bval = '0;
  int           outst = 0;
  bit           rdy_m = 0;
  longint       aws = 0;
  longint       ws = 0;

  logic [96:0]  s_aw_v;
  logic [96:0]  m_aw_v;
  logic [144:0] s_w_v;
  logic [144:0] m_w_v;

  assign s_aw_v = {s_awid, s_awaddr, s_awlen, s_awsize,
                   s_awburst, s_awcache, s_awlock,
                   s_awprot, s_awqos, s_awregion};
  assign m_aw_v = {m_awid, m_awaddr, m_awlen, m_awsize,
                   m_awburst, m_awcache, m_awlock,
                   m_awprot, m_awqos, m_awregion};
  assign s_w_v  = {s_wdata, s_wstrb, s_wlast};
  assign m_w_v  = {m_wdata, m_wstrb, m_wlast};

  dbchecker_rx_wbuf #(
    .AW_DEPTH  (AWD),
    .W_DEPTH   (WD),
    .MAX_OUTST (MO)
  ) dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .s_axi_io_rx_awid     (s_awid),
    .s_axi_io_rx_awaddr   (s_awaddr),
    .s_axi_io_rx_awlen    (s_awlen),
    .s_axi_io_rx_awsize   (s_awsize),
    .s_axi_io_rx_awburst  (s_awburst),
    .s_axi_io_rx_awcache  (s_awcache),
    .s_axi_io_rx_awlock   (s_awlock),
    .s_axi_io_rx_awprot   (s_awprot),
    .s_axi_io_rx_awqos    (s_awqos),
    .s_axi_io_rx_awregion (s_awregion),
    .s_axi_io_rx_awvalid  (s_awvalid),
    .s_axi_io_rx_awready  (s_awready),
    .s_axi_io_rx_wdata    (s_wdata),
    .s_axi_io_rx_wstrb    (s_wstrb),
    .s_axi_io_rx_wlast    (s_wlast),
    .s_axi_io_rx_wvalid   (s_wvalid),
    .s_axi_io_rx_wready   (s_wready),
    .s_axi_io_rx_bid      (s_bid),
    .s_axi_io_rx_bresp    (s_bresp),
    .s_axi_io_rx_bvalid   (s_bvalid),
    .s_axi_io_rx_bready   (s_bready),
    .m_axi_io_rx_awid     (m_awid),
    .m_axi_io_rx_awaddr   (m_awaddr),
    .m_axi_io_rx_awlen    (m_awlen),
    .m_axi_io_rx_awsize   (m_awsize),
    .m_axi_io_rx_awburst  (m_awburst),
    .m_axi_io_rx_awcache  (m_awcache),
    .m_axi_io_rx_awlock   (m_awlock),
    .m_axi_io_rx_awprot   (m_awprot),
    .m_axi_io_rx_awqos    (m_awqos),
    .m_axi_io_rx_awregion (m_awregion),
    .m_axi_io_rx_awvalid  (m_awvalid),
    .m_axi_io_rx_awready  (m_awready),
    .m_axi_io_rx_wdata    (m_wdata),
    .m_axi_io_rx_wstrb    (m_wstrb),
    .m_axi_io_rx_wlast    (m_wlast),
    .m_axi_io_rx_wvalid   (m_wvalid),
    .m_axi_io_rx_wready   (m_wready),
    .m_axi_io_rx_bid      (m_bid),
    .m_axi_io_rx_bresp    (m_bresp),
    .m_axi_io_rx_bvalid   (m_bvalid),
    .m_axi_io_rx_bready   (m_bready),
    .outst_cnt            (outst_cnt)
`ifdef DBCHECKER_RX_WBUF_STATS_EN
    ,
    .aw_stall_cnt         (aw_stall_cnt),
    .w_stall_cnt          (w_stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm,
                     input logic [159:0] act,
                     input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // compare DUT against the queue model, then advance the model
  always @(negedge clock) begin : cmp
    logic         e_sawr, e_mawv, e_swr, e_mwv, e_mbr;
    logic [96:0]  e_aw;
    logic [144:0] e_w;
    if (!reset_n) begin
      awq.delete();
      wq.delete();
      bslot = 0;
      bval = '0;
      outst = 0;
      rdy_m = 0;
      aws = 0;
      ws = 0;
    end
    e_sawr = rdy_m && (awq.size() < AWD);
    e_swr  = rdy_m && (wq.size() < WD);
    e_mawv = (awq.size() > 0) && (outst < MO);
    e_mwv  = (wq.size() > 0);
    e_mbr  = rdy_m && (!bslot || s_bready);
    e_aw   = (awq.size() > 0) ? awq[0] : '0;
    e_w    = (wq.size() > 0) ? wq[0] : '0;
    chk("s_awready", 160'(s_awready), 160'(e_sawr));
    chk("s_wready", 160'(s_wready), 160'(e_swr));
    chk("m_awvalid", 160'(m_awvalid), 160'(e_mawv));
    chk("m_wvalid", 160'(m_wvalid), 160'(e_mwv));
    chk("m_bready", 160'(m_bready), 160'(e_mbr));
    chk("s_bvalid", 160'(s_bvalid), 160'(bslot));
    chk("s_b_fields", 160'({s_bid, s_bresp}), 160'(bval));
    chk("m_aw_fields", 160'(m_aw_v), 160'(e_aw));
    chk("m_w_fields", 160'(m_w_v), 160'(e_w));
    chk("outst_cnt", 160'(outst_cnt), 160'(outst));
`ifdef DBCHECKER_RX_WBUF_STATS_EN
    chk("aw_stall", 160'(aw_stall_cnt), 160'(aws));
    chk("w_stall", 160'(w_stall_cnt), 160'(ws));
`endif
    if (reset_n) begin
      if (e_mawv && !m_awready && aws < 64'hFFFF_FFFF) aws++;
      if (e_mwv && !m_wready && ws < 64'hFFFF_FFFF) ws++;
      if (e_mawv && m_awready) awq.delete(0);
      if (s_awvalid && e_sawr) awq.push_back(s_aw_v);
      if (e_mwv && m_wready) wq.delete(0);
      if (s_wvalid && e_swr) wq.push_back(s_w_v);
      if (bslot && s_bready) begin
        if (outst > 0) outst--;
        bslot = 0;
      end
      if (e_mawv && m_awready) outst++;
      if (m_bvalid && e_mbr) begin
        bslot = 1;
        bval = {m_bid, m_bresp};
      end
      rdy_m = 1;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    s_awvalid = 0;
    s_wvalid = 0;
    m_bvalid = 0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 0;
    step();
    step();
    reset_n = 1;
    step();
  endtask

  task automatic rand_in();
    s_awvalid  = ($urandom_range(0, 99) < 50);
    s_awid     = 4'($urandom);
    s_awaddr   = {$urandom, $urandom};
    s_awlen    = 8'($urandom);
    s_awsize   = 3'($urandom);
    s_awburst  = 2'($urandom);
    s_awcache  = 4'($urandom);
    s_awlock   = 1'($urandom);
    s_awprot   = 3'($urandom);
    s_awqos    = 4'($urandom);
    s_awregion = 4'($urandom);
    s_wvalid   = ($urandom_range(0, 99) < 60);
    s_wdata    = {$urandom, $urandom, $urandom, $urandom};
    s_wstrb    = 16'($urandom);
    s_wlast    = 1'($urandom);
    m_awready  = ($urandom_range(0, 99) < 60);
    m_wready   = ($urandom_range(0, 99) < 60);
    m_bvalid   = ($urandom_range(0, 99) < 30);
    m_bid      = 4'($urandom);
    m_bresp    = 2'($urandom);
    s_bready   = ($urandom_range(0, 99) < 70);
  endtask

  initial begin
    s_awid = '0; s_awaddr = '0; s_awlen = '0;
    s_awsize = '0; s_awburst = '0; s_awcache = '0;
    s_awlock = 0; s_awprot = '0; s_awqos = '0;
    s_awregion = '0; s_awvalid = 0;
    s_wdata = '0; s_wstrb = '0; s_wlast = 0;
    s_wvalid = 0; s_bready = 0;
    m_awready = 0; m_wready = 0;
    m_bid = '0; m_bresp = '0; m_bvalid = 0;
    #2;
    chk("rst_awready", 160'(s_awready), 160'(1'b0));
    chk("rst_wready", 160'(s_wready), 160'(1'b0));
    chk("rst_bready", 160'(m_bready), 160'(1'b0));
    chk("rst_outst", 160'(outst_cnt), 160'(8'd0));
    do_reset();

    // AW fill to full, limited issue, B return
    m_awready = 0;
    s_bready = 1;
    for (int i = 1; i <= 4; i++) begin
      s_awvalid = 1;
      s_awid = 4'(i);
      s_awaddr = 64'(i) * 64'h1000;
      #1 chk("aw_fill_rdy", 160'(s_awready), 160'(1'b1));
      step();
    end
    s_awid = 4'd5;
    #1 chk("aw_full_rdy", 160'(s_awready), 160'(1'b0));
    step();
    #1 chk("aw_held", 160'(s_awready), 160'(1'b0));
    step();
    m_awready = 1;
    #1;
    chk("r1_id", 160'(m_awid), 160'(4'd1));
    chk("r1_outst", 160'(outst_cnt), 160'(8'd0));
    chk("r1_fullpop_rdy", 160'(s_awready), 160'(1'b0));
    step();
    #1;
    chk("r2_id", 160'(m_awid), 160'(4'd2));
    chk("r2_outst", 160'(outst_cnt), 160'(8'd1));
    step();
    s_awvalid = 0;
    #1;
    chk("r3_outst", 160'(outst_cnt), 160'(8'd2));
    chk("r3_blocked", 160'(m_awvalid), 160'(1'b0));
    step();
    m_bvalid = 1; m_bid = 4'd3; m_bresp = 2'd0;
    #1 chk("b1_bready", 160'(m_bready), 160'(1'b1));
    step();
    m_bvalid = 0;
    #1;
    chk("b2_bid", 160'(s_bid), 160'(4'd3));
    chk("b2_outst", 160'(outst_cnt), 160'(8'd2));
    step();
    #1;
    chk("b3_outst", 160'(outst_cnt), 160'(8'd1));
    chk("b3_awid", 160'(m_awid), 160'(4'd3));
    chk("b3_awv", 160'(m_awvalid), 160'(1'b1));
    step();
    s_bready = 0; m_bvalid = 1; m_bid = 4'd4;
    #1 chk("b4_outst", 160'(outst_cnt), 160'(8'd2));
    step();
    s_bready = 1; m_bid = 4'd5;
    #1 chk("x_bid", 160'(s_bid), 160'(4'd4));
    step();
    m_bvalid = 0;
    #1;
    chk("y_outst", 160'(outst_cnt), 160'(8'd1));
    chk("y_awid", 160'(m_awid), 160'(4'd4));
    chk("y_bvalid", 160'(s_bvalid), 160'(1'b1));
    step();
    #1 chk("z_outst_same", 160'(outst_cnt), 160'(8'd1));
    step();
    do_reset();

    // W before AW, 16-beat burst
    m_wready = 0;
    m_awready = 1;
    for (int k = 0; k < 16; k++) begin
      s_wvalid = 1;
      s_wdata = 128'(k) + 128'h100;
      s_wstrb = 16'hFFFF;
      s_wlast = (k == 15);
      #1 chk("w_fill_rdy", 160'(s_wready), 160'(1'b1));
      step();
    end
    s_wvalid = 0;
    #1 chk("w_full_rdy", 160'(s_wready), 160'(1'b0));
    step();
    m_wready = 1;
    s_awvalid = 1; s_awid = 4'd7; s_awlen = 8'd15;
    for (int k = 0; k < 16; k++) begin
      if (k == 1) s_awvalid = 0;
      #1;
      chk("w_beat", 160'(m_wdata), 160'(128'(k) + 128'h100));
      chk("w_last", 160'(m_wlast), 160'(k == 15));
      if (k == 1) chk("aw_after_w", 160'(m_awid), 160'(4'd7));
      step();
    end
    #1 chk("w_drained", 160'(m_wvalid), 160'(1'b0));
    do_reset();

    // reset with buffered W beats
    m_wready = 0;
    for (int k = 0; k < 5; k++) begin
      s_wvalid = 1;
      s_wdata = 128'(k) + 128'h55;
      step();
    end
    s_wvalid = 0;
    reset_n = 0;
    #1 chk("rst_w_gone", 160'(m_wvalid), 160'(1'b0));
    step();
    reset_n = 1;
    #1 chk("rel_outst", 160'(outst_cnt), 160'(8'd0));
    step();
    #1 chk("rel_nowv", 160'(m_wvalid), 160'(1'b0));
    s_wvalid = 1; s_wdata = 128'hAB; s_wlast = 1;
    #1 chk("new_not_yet", 160'(m_wvalid), 160'(1'b0));
    step();
    s_wvalid = 0;
    #1;
    chk("new_valid", 160'(m_wvalid), 160'(1'b1));
    chk("new_data", 160'(m_wdata), 160'(128'hAB));
    step();
    for (int k = 0; k < 9; k++) step();
`ifdef DBCHECKER_RX_WBUF_STATS_EN
    #1 chk("w_stall_10", 160'(w_stall_cnt), 160'(32'd10));
`endif
    do_reset();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 750 == 749) do_reset();
      rand_in();
      step();
    end
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
